// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch controller: owns the fetch PC, runs a single-outstanding
// instruction-memory handshake and hands fetched words to ID with valid/ready.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    input  logic [31:0] trap_vector,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    input  logic        id_ready,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        imem_req_q, imem_req_d;
    logic        if_valid_q, if_valid_d;

    logic        redir_ev_s;
    logic [31:0] redir_raw_s;
    logic [31:0] redir_tgt_s;

    // Trap outranks a branch redirect; targets are always word aligned.
    assign redir_ev_s  = trap | redirect;
    assign redir_raw_s = trap ? trap_vector : redirect_pc;
    assign redir_tgt_s = {redir_raw_s[31:2], 2'b00};

    // Next-state and datapath update for the fetch sequencer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redir_ev_s) begin
                    pc_d = redir_tgt_s;
                    // A grant in the redirect cycle leaves a stale response to drop.
                    if (imem_gnt) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redir_ev_s) begin
                    pc_d = redir_tgt_s;
                    if (imem_rvalid) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (imem_rvalid) begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = req_pc_q;
                    if_valid_d = 1'b1;
                    state_d    = ST_OUT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (redir_ev_s) begin
                    pc_d = redir_tgt_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (redir_ev_s) begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    pc_d       = redir_tgt_s;
                    state_d    = ST_REQ;
                end else if (id_ready) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    if_valid_d    = 1'b0;
                    if_instr_d    = NOP_INSTR;
                    state_d       = ST_REQ;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d    = ST_BOOT;
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
        endcase

        imem_req_d = (state_d == ST_REQ);
    end

    // State and registered outputs; reset abandons any in-flight fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            req_pc_q      <= 32'd0;
            if_pc_q       <= 32'd0;
            if_instr_q    <= NOP_INSTR;
            if_valid_q    <= 1'b0;
            fetch_count_q <= 32'd0;
            imem_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
            imem_req_q    <= imem_req_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_q + 32'd4;
    assign if_instr    = if_instr_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a stimulus process drives memory/ID/redirects
// and pushes expected instructions; a negedge monitor pops and compares on handshakes.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect, trap, imem_gnt, imem_rvalid, id_ready;
    logic [31:0] redirect_pc, trap_vector, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_pc, if_pc_plus4, if_instr, fetch_count;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .trap(trap), .trap_vector(trap_vector),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_instr(if_instr), .id_ready(id_ready), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] model_next;
    bit          boot_slot;
    int          rv_cnt;
    logic [31:0] rv_addr;
    bit          last_gnt;

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_if_pc"}, if_pc, 32'd0);
        chk({tag, "_if_pc_plus4"}, if_pc_plus4, 32'd4);
        chk({tag, "_if_instr"}, if_instr, NOP_INSTR);
        chk({tag, "_fetch_count"}, fetch_count, 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, RESET_PC);
    endtask

    // One clock slot: memory responder, stimulus, and the architectural model.
    task automatic step(input bit g, input bit rdy, input bit rd, input logic [31:0] rpc,
                        input bit tr, input logic [31:0] tv, input int dly,
                        input bit rel, input bit arst);
        bit          rv_now;
        bit          ev;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        if (rel) begin
            rst        = 1'b0;
            boot_slot  = 1'b1;
            model_next = RESET_PC;
            sb.delete();
        end
        rv_now = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            rv_now = (rv_cnt == 0);
        end
        imem_rvalid = rv_now;
        imem_rdata  = rv_now ? mem_word(rv_addr) : $urandom;
        last_gnt    = g && imem_req && (rv_cnt == 0) && !rv_now && !rst;
        imem_gnt    = last_gnt;
        id_ready    = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        trap        = tr;
        trap_vector = tv;
        ev  = (rd || tr) && !boot_slot && !rst;
        tgt = tr ? tv : rpc;
        tgt[1:0] = 2'b00;
        if (last_gnt) begin
            rv_cnt  = dly;
            rv_addr = imem_addr;
            if (!ev) begin
                chk("imem_addr", imem_addr, model_next);
                sb.push_back('{model_next, mem_word(model_next)});
            end
        end
        if (ev) begin
            model_next = tgt;
            sb.delete();
        end else if (if_valid && rdy && !rst) begin
            model_next = model_next + 32'd4;
        end
        boot_slot = 1'b0;
        if (arst) begin
            #2;
            rst = 1'b1;
            #1;
            check_reset_outputs("arst");
            sb.delete();
        end
    endtask

    task automatic stepn(input bit g, input bit rdy, input int dly);
        step(g, rdy, 1'b0, 32'd0, 1'b0, 32'd0, dly, 1'b0, 1'b0);
    endtask

    // Leaves the DUT in REQ with no grant given, so the next slot is also REQ.
    task automatic wait_req();
        int n = 0;
        do begin
            stepn(1'b0, 1'b1, 1);
            n++;
        end while (!imem_req && n < 20);
        chk("wait_req", 32'(imem_req), 32'd1);
    endtask

    task automatic grant_now(input int dly);
        wait_req();
        stepn(1'b1, 1'b1, dly);
        chk("granted", 32'(last_gnt), 32'd1);
    endtask

    // Monitor: compares every counted ID handshake against the scoreboard.
    initial begin
        bit          prev_hold;
        logic [31:0] prev_pc, prev_instr;
        int          mon_acc;
        exp_t        e;
        prev_hold = 1'b0;
        mon_acc   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                mon_acc   = 0;
            end else begin
                chk("fetch_count", fetch_count, 32'(mon_acc));
                if (!if_valid) chk("nop_when_idle", if_instr, NOP_INSTR);
                if (prev_hold) begin
                    chk("hold_valid", 32'(if_valid), 32'd1);
                    chk("hold_pc", if_pc, prev_pc);
                    chk("hold_instr", if_instr, prev_instr);
                    chk("hold_no_req", 32'(imem_req), 32'd0);
                end
                if (if_valid && id_ready && !redirect && !trap) begin
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_underflow: got instr at pc %h, want none", if_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("if_pc", if_pc, e.pc);
                        chk("if_instr", if_instr, e.instr);
                        chk("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
                        mon_acc++;
                    end
                end
                prev_hold  = if_valid && !id_ready && !redirect && !trap;
                prev_pc    = if_pc;
                prev_instr = if_instr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        redirect = 1'b0; trap = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
        redirect_pc = 32'd0; trap_vector = 32'd0; imem_rdata = 32'd0;
        rv_cnt = 0; rv_addr = 32'd0; model_next = RESET_PC; boot_slot = 1'b0; last_gnt = 1'b0;
        #3;
        check_reset_outputs("por");

        // Release with a redirect in the BOOT slot, which must be ignored.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 32'd0, 1, 1'b1, 1'b0);
        chk("boot_no_req", 32'(imem_req), 32'd0);
        stepn(1'b1, 1'b1, 1);
        chk("first_req", 32'(imem_req), 32'd1);
        repeat (12) stepn(1'b1, 1'b1, 1);
        chk("fetch_count_4", fetch_count, 32'd4);

        // Stall ID for five cycles in OUT, then release.
        stepn(1'b1, 1'b1, 1);
        repeat (5) stepn(1'b1, 1'b0, 1);
        repeat (4) stepn(1'b1, 1'b1, 1);

        // Redirect while waiting; the late response is dropped.
        grant_now(2);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'd0, 1, 1'b0, 1'b0);
        stepn(1'b0, 1'b1, 1);
        stepn(1'b0, 1'b1, 1);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        repeat (6) stepn(1'b1, 1'b1, 1);

        // Trap and redirect together on a granted request.
        wait_req();
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0080, 2, 1'b0, 1'b0);
        chk("trap_gnt", 32'(last_gnt), 32'd1);
        repeat (3) stepn(1'b0, 1'b1, 1);
        chk("trap_req", 32'(imem_req), 32'd1);
        chk("trap_addr", imem_addr, 32'h0000_0080);
        repeat (6) stepn(1'b1, 1'b1, 1);

        // Wrap of the address space.
        wait_req();
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1, 1'b0, 1'b0);
        repeat (9) stepn(1'b1, 1'b1, 1);

        // Asynchronous reset while waiting for data; response lands in REQ.
        grant_now(4);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1, 1'b0, 1'b1);
        stepn(1'b0, 1'b0, 1);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1, 1'b1, 1'b0);
        repeat (30) stepn(1'b1, 1'b1, 1);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 8,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom,
                 $urandom_range(0, 99) < 4, $urandom,
                 $urandom_range(1, 3), 1'b0, 1'b0);
        end
        repeat (10) stepn(1'b1, 1'b1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the program counter and the instruction-memory fetch handshake for the IF stage of the pipelined RISC-V core.
- Holds the fetch PC and advances it by 4, like the existing PC adder does (mod 2^32).
- Issues requests to instruction memory and presents fetched instructions to ID with a valid/ready handshake.
- Handles branch/jump and trap redirects, including killing fetches already in flight.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- redirect  input  1  branch/jump taken from EX; load redirect_pc.
- redirect_pc  input  32  branch/jump target.
- trap  input  1  exception/interrupt redirect; higher priority than redirect.
- trap_vector  input  32  trap handler address.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; equals pc while imem_req=1.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid; exactly one per granted request, at least 1 cycle after grant.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  instruction held for ID.
- if_pc  output  32  PC of the held instruction.
- if_pc_plus4  output  32  if_pc + 4, wraps mod 2^32.
- if_instr  output  32  held instruction, NOP_INSTR when if_valid=0.
- id_ready  input  1  ID accepts the instruction (deasserted on hazard stall).
- fetch_count  output  32  number of instructions accepted by ID; wraps.

Behaviour:
- Reset (async, any state): pc=RESET_PC, req_pc=0, state=BOOT, imem_req=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR, fetch_count=0. Async reset mid-operation abandons any in-flight fetch; a late rvalid after reset release is ignored in BOOT/REQ.
- Redirect target = trap ? trap_vector : redirect_pc, with bits [1:0] forced to 00. "Redirect event" = trap | redirect. It is sampled every cycle in every state except BOOT, where it is ignored.
- BOOT: imem_req=0. Goes to REQ on the next cycle.
- REQ: imem_req=1, imem_addr=pc.
  - Redirect with imem_gnt=0: pc<=target, stay REQ.
  - Redirect with imem_gnt=1: the granted fetch is stale; pc<=target, go DRAIN.
  - imem_gnt=1 with no redirect: req_pc<=pc, pc<=pc+4 (32'hFFFF_FFFC+4 = 0), go WAIT.
- WAIT: imem_req=0.
  - Redirect (with or without rvalid in the same cycle): pc<=target, discard data. Go REQ if rvalid=1, else DRAIN.
  - rvalid with no redirect: if_instr<=imem_rdata, if_pc<=req_pc, if_valid<=1, go OUT.
- DRAIN: imem_req=0. Redirects update pc and stay DRAIN. The next rvalid is discarded; go REQ.
- OUT: if_valid=1; outputs stable while id_ready=0.
  - Redirect: if_valid<=0, if_instr<=NOP_INSTR, pc<=target, go REQ. A redirect in the same cycle as id_ready=1 takes priority, and the handshake is not counted.
  - id_ready=1 with no redirect: fetch_count+=1, if_valid<=0, if_instr<=NOP_INSTR, go REQ.
- Priority: rst > trap > redirect > memory/ID handshakes.
- Latency:
  - First imem_req is 1 cycle after reset release.
  - With gnt in the REQ cycle and rvalid 1 cycle later, if_valid rises 2 cycles after the request cycle.
  - Steady-state throughput is 1 instruction per 3 cycles; no fetch overlap.
- if_pc_plus4 is combinational from if_pc.
- At most one outstanding memory request at any time.

Test Plan:
- Reset with RESET_PC=0; then imem_gnt=1 at every request, rvalid 1 cycle after, id_ready=1 -> imem_addr sequence 0,4,8,12. if_instr matches rdata, if_pc_plus4=if_pc+4, fetch_count=4 after 4 handshakes.
- Hold id_ready=0 for 5 cycles in OUT -> if_valid, if_pc, if_instr stable; no imem_req; fetch_count unchanged. Release -> next fetch at if_pc+4.
- redirect=1, redirect_pc=32'h0000_0103 in WAIT with rvalid 2 cycles later -> rvalid data discarded (if_valid stays 0); next imem_addr=32'h0000_0100.
- trap=1 (trap_vector=32'h80) and redirect=1 (redirect_pc=32'h200) in the same cycle in REQ with gnt=1 -> DRAIN; the next request is addressed to 32'h80.
- Wrap: redirect to 32'hFFFF_FFFC, complete fetch -> if_pc=32'hFFFF_FFFC, if_pc_plus4=0, next imem_addr=0.
- Assert rst asynchronously (mid-cycle) while in WAIT -> outputs immediately at reset values. Release -> first imem_addr=RESET_PC; the pending rvalid arriving during BOOT/REQ is ignored.
